div_32bit_seq: RTL and testbench

Multi-cycle 32-bit integer divider for the processor's DIV/DIVU path. It implements restoring division, one quotient bit per clock. Signed operands are converted to magnitudes by two's-complement negation (bitwise inversion plus one) and the results are re-signed at the end. The block sits beside the ALU: the control unit pulses `start` and stalls until `done`, then writes `quotient` to LO and `remainder` to HI.

---
 rtl/alu_pkg.sv | 16 +
 rtl/div_32bit_seq_if.sv | 25 ++
 rtl/negate_32bit.sv | 14 +
 rtl/div_32bit_seq.sv | 129 ++++++++++++
 tb/tb_div_32bit_seq.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the sequential divider.
package alu_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

  localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

endpackage

// File: rtl/div_32bit_seq_if.sv
// Request/response bundle between the control unit and the divider.
interface div_32bit_seq_if;
  import alu_pkg::*;

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/negate_32bit.sv
// Combinational two's complement: bitwise inversion followed by +1.
module negate_32bit
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] inv;

  assign inv = ~a_i;
  assign y_o = inv + WIDTH'(1);

endmodule

// File: rtl/div_32bit_seq.sv
// Restoring divider, one quotient bit per clock, with signed operand/result fixup.
module div_32bit_seq
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  div_32bit_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             dz_q, dz_d, dzo_q, dzo_d, done_q, done_d;

  logic [WIDTH-1:0] neg_a_in, neg_a_out, neg_b_in, neg_b_out;
  logic [WIDTH:0]   rem_sh, trial;

  // Negators are shared: operand conditioning in IDLE, result fixup in FIX.
  assign neg_a_in = (state_q == StIdle) ? bus.dividend : dvd_q;
  assign neg_b_in = (state_q == StIdle) ? bus.divisor  : rem_q;

  negate_32bit u_neg_a (
    .a_i (neg_a_in),
    .y_o (neg_a_out)
  );

  negate_32bit u_neg_b (
    .a_i (neg_b_in),
    .y_o (neg_b_out)
  );

  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign trial  = rem_sh + {1'b1, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (cnt_q == '0) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dzo_d   = dzo_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          dvd_d   = (bus.is_signed && bus.dividend[WIDTH-1]) ? neg_a_out : bus.dividend;
          dvs_d   = (bus.is_signed && bus.divisor[WIDTH-1])  ? neg_b_out : bus.divisor;
          q_neg_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          r_neg_d = bus.is_signed & bus.dividend[WIDTH-1];
          dz_d    = (bus.divisor == '0);
          rem_d   = '0;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      StRun: begin
        // trial[WIDTH] set means the subtraction went negative: keep shifted remainder.
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
      end
      StFix: begin
        quot_d = dz_q ? DIV_ZERO_QUOT : (q_neg_q ? neg_a_out : dvd_q);
        remo_d = r_neg_q ? neg_b_out : rem_q;
        dzo_d  = dz_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dzo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dzo_q   <= dzo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dzo_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed-vector bench for div_32bit_seq: results, latency, reset and start handling.
module tb_div_32bit_seq;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  div_32bit_seq_if dut_if ();

  div_32bit_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drives start now; returns at #1 after the completion edge (inside the done cycle).
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input int inj, input logic [31:0] eq,
                       input logic [31:0] er, input logic edz);
    int   n;
    logic gap;
    dut_if.start     = 1'b1;
    dut_if.dividend  = a;
    dut_if.divisor   = b;
    dut_if.is_signed = sgn;
    @(posedge clk);
    #1;
    dut_if.start    = 1'b0;
    dut_if.dividend = ~a;
    dut_if.divisor  = b ^ 32'h5A5A_0F0F;
    check_val({tag, ".busy0"}, 32'(dut_if.busy), 32'd1);
    check_val({tag, ".done0"}, 32'(dut_if.done), 32'd0);
    n   = 0;
    gap = 1'b0;
    while (1) begin
      if (inj > 0 && n == inj) begin
        dut_if.start     = 1'b1;
        dut_if.dividend  = 32'd1000;
        dut_if.divisor   = 32'd3;
        dut_if.is_signed = ~sgn;
      end else begin
        dut_if.start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (dut_if.done) break;
      if (!dut_if.busy) gap = 1'b1;
      if (n >= 40) break;
    end
    check_val({tag, ".lat"}, 32'(n), 32'd33);
    check_val({tag, ".gap"}, 32'(gap), 32'd0);
    check_val({tag, ".busy"}, 32'(dut_if.busy), 32'd0);
    check_val({tag, ".q"}, dut_if.quotient, eq);
    check_val({tag, ".r"}, dut_if.remainder, er);
    check_val({tag, ".dz"}, 32'(dut_if.div_by_zero), 32'(edz));
  endtask

  task automatic idle_edge(input string tag);
    @(posedge clk);
    #1;
    check_val({tag, ".drop"}, 32'(dut_if.done), 32'd0);
  endtask

  initial begin
    n_total          = 0;
    n_bad            = 0;
    rst_n            = 1'b0;
    dut_if.start     = 1'b0;
    dut_if.is_signed = 1'b0;
    dut_if.dividend  = '0;
    dut_if.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.busy", 32'(dut_if.busy), 32'd0);
    check_val("rst.done", 32'(dut_if.done), 32'd0);
    check_val("rst.q", dut_if.quotient, 32'd0);
    check_val("rst.r", dut_if.remainder, 32'd0);
    check_val("rst.dz", 32'(dut_if.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("u100_7", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0);
    idle_edge("u100_7");
    do_op("sm100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    idle_edge("sm100_7");
    do_op("s100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 0, 32'hFFFF_FFF2, 32'd2, 1'b0);
    idle_edge("s100_m7");
    do_op("u5_0", 32'd5, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    idle_edge("u5_0");
    do_op("s5_0", 32'd5, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    idle_edge("s5_0");
    do_op("sm5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    idle_edge("sm5_0");
    do_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0);
    idle_edge("sovf");
    do_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    idle_edge("umax_1");

    // Mid-run start ignored, then a back-to-back start issued in the done cycle.
    do_op("inj", 32'd100, 32'd7, 1'b0, 5, 32'd14, 32'd2, 1'b0);
    do_op("b2b", 32'd1000, 32'd3, 1'b0, 0, 32'd333, 32'd1, 1'b0);
    idle_edge("b2b");

    // Reset ten cycles into RUN.
    dut_if.start     = 1'b1;
    dut_if.dividend  = 32'd100;
    dut_if.divisor   = 32'd7;
    dut_if.is_signed = 1'b0;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("mid.busy", 32'(dut_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid.busy0", 32'(dut_if.busy), 32'd0);
    check_val("mid.done0", 32'(dut_if.done), 32'd0);
    check_val("mid.q0", dut_if.quotient, 32'd0);
    check_val("mid.r0", dut_if.remainder, 32'd0);
    check_val("mid.dz0", 32'(dut_if.div_by_zero), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_val("mid.nodone", 32'(dut_if.done), 32'd0);
    do_op("post", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    idle_edge("post");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
